// File: rtl/fnd_scan_ctrl.sv
// Digit scan sequencer for a 4-digit common-anode FND: slot timing, mux select,
// active-low commons with dead time, per-digit blanking/blink and frame-aligned page latch.
module fnd_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYC     = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_page,
    input  logic [3:0] i_digit_en,
    input  logic [3:0] i_blink_mask,
    output logic [2:0] o_mux_sel,
    output logic [3:0] o_fnd_com,
    output logic       o_frame_tick,
    output logic       o_blink_phase
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_V   = CNT_W'(DEAD_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             page_q, page_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             run_q, run_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       fnd_com_q, fnd_com_d;

    logic             scan_tick;
    logic             frame_start;
    logic             com_enable;
    logic [3:0]       digit_on;

    always_comb begin
        scan_tick     = (cnt_q == CNT_LAST);
        frame_start   = scan_tick && (idx_q == 2'd3);
        cnt_d         = scan_tick ? '0 : cnt_q + CNT_W'(1);
        idx_d         = scan_tick ? idx_q + 2'd1 : idx_q;
        // Commons stay dark until the first scan_tick selects digit 0.
        run_d         = run_q | scan_tick;
        page_d        = frame_start ? i_page : page_q;
        frame_tick_d  = frame_start;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Commons are decoded from the post-edge state so they line up with o_mux_sel.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_on[gi] = (idx_d == 2'(gi)) && i_digit_en[gi]
                                  && !(blink_phase_d && i_blink_mask[gi]);
        end
    endgenerate

    always_comb begin
        com_enable = run_d && (cnt_d >= DEAD_V);
        fnd_com_d  = ~(digit_on & {4{com_enable}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd3;
            page_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            run_q         <= 1'b0;
            frame_tick_q  <= 1'b0;
            fnd_com_q     <= 4'b1111;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            page_q        <= page_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            run_q         <= run_d;
            frame_tick_q  <= frame_tick_d;
            fnd_com_q     <= fnd_com_d;
        end
    end

    assign o_mux_sel     = {page_q, idx_q};
    assign o_fnd_com     = fnd_com_q;
    assign o_frame_tick  = frame_tick_q;
    assign o_blink_phase = blink_phase_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a cycle-count reference model queues expected
// outputs at each rising edge; a monitor pops and compares them on the falling edge.
module tb_fnd_scan_ctrl;

    localparam int SD = 4;
    localparam int DC = 1;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_page = 1'b0;
    logic [3:0] i_digit_en = 4'b1111;
    logic [3:0] i_blink_mask = 4'b0000;
    logic [2:0] o_mux_sel;
    logic [3:0] o_fnd_com;
    logic       o_frame_tick;
    logic       o_blink_phase;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] com;
        logic       tick;
        logic       ph;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    logic mpage = 1'b0;
    bit   started = 1'b0;

    fnd_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_page       (i_page),
        .i_digit_en   (i_digit_en),
        .i_blink_mask (i_blink_mask),
        .o_mux_sel    (o_mux_sel),
        .o_fnd_com    (o_fnd_com),
        .o_frame_tick (o_frame_tick),
        .o_blink_phase(o_blink_phase)
    );

    always #5 clk = ~clk;

    // Outputs for cycle tt after reset release: slot k = tt/SD, slot 0 is the pre-scan slot.
    function automatic exp_t model(int tt, logic pg, logic [3:0] en, logic [3:0] mk);
        int   k, c, idx, nfs;
        exp_t e;
        k     = tt / SD;
        c     = tt % SD;
        idx   = (k + 3) % 4;
        nfs   = (k >= 1) ? ((k - 1) / 4 + 1) : 0;
        e.sel = {pg, 2'(idx)};
        e.ph  = ((nfs / BF) % 2) == 1;
        e.tick = (k >= 1) && (c == 0) && (((k - 1) % 4) == 0);
        e.com = 4'b1111;
        if (k >= 1 && c >= DC && en[idx] && !(e.ph && mk[idx]))
            e.com[idx] = 1'b0;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t     = 0;
                mpage = 1'b0;
            end else begin
                t = t + 1;
                if ((t % SD) == 0 && (t / SD) >= 1 && (((t / SD) - 1) % 4) == 0)
                    mpage = i_page;
            end
            sb.push_back(model(t, mpage, i_digit_en, i_blink_mask));
            started = 1'b1;
        end
    end

    task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0d", nm, act, req, t);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 8'd0, 8'd1);
                end else begin
                    e = sb.pop_front();
                    if (!rst_n) begin
                        e.sel  = 3'b011;
                        e.com  = 4'b1111;
                        e.tick = 1'b0;
                        e.ph   = 1'b0;
                    end
                    chk("mux_sel", 8'(o_mux_sel), 8'(e.sel));
                    chk("fnd_com", 8'(o_fnd_com), 8'(e.com));
                    chk("frame_tick", 8'(o_frame_tick), 8'(e.tick));
                    chk("blink_phase", 8'(o_blink_phase), 8'(e.ph));
                    chk("com_one_low", 8'($countones(~o_fnd_com) <= 1), 8'd1);
                    $display("t=%0d rst_n=%b sel=%b com=%b tick=%b ph=%b", t, rst_n,
                             o_mux_sel, o_fnd_com, o_frame_tick, o_blink_phase);
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;
        step(3);
        rst_n = 1'b1;
        step(40);

        i_page = 1'b1;
        step(40);
        i_page = 1'b0;
        step(40);

        i_digit_en = 4'b1011;
        step(20);
        i_digit_en = 4'b1111;

        i_blink_mask = 4'b0001;
        step(70);
        i_blink_mask = 4'b0000;

        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (((t / SD) % 4) == 3 && (t % SD) == 2) found = 1'b1;
            else step(1);
        end
        chk("reach_idx2_cnt2", 8'(found), 8'd1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(40);

        for (int i = 0; i < 300; i++) begin
            step(1);
            if ($urandom_range(0, 7) == 0) i_page = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) i_digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) i_blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
        end
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
